branch_resolution_unit_pipelined: RTL

- Registered branch/jump resolution unit for the MIPS ID stage; the successor to the combinational low-latency address calculator.
- Decodes the branch flag, evaluates BEQ/BNE conditions, and computes the J/JAL/JR/JALR/branch targets, truncated to instruction-memory address width.
- Drives the fetch redirect, a multi-cycle flush toward the IF/ID latch, a link address, a sticky exception disable to the hazard detection unit, and a saturating taken-branch counter.

---
 rtl/branch_resolution_unit_pipelined.sv | 130 +++++++++++++
 1 files changed

// File: rtl/branch_resolution_unit_pipelined.sv
// Registered branch/jump resolution for the ID stage: evaluates BEQ/BNE/J/JAL/JR/JALR,
// drives a one-cycle fetch redirect, a multi-cycle IF/ID flush, a link address and a sticky exception.
module branch_resolution_unit_pipelined #(
    parameter int unsigned CANT_BITS_ADDR                     = 11,
    parameter int unsigned CANT_BITS_INSTRUCTION_INDEX_BRANCH = 26,
    parameter int unsigned CANT_BITS_FLAG_BRANCH              = 3,
    parameter int unsigned CANT_BITS_REGISTROS                = 32,
    parameter int unsigned CANT_CICLOS_FLUSH                  = 1,
    parameter int unsigned CANT_BITS_CONTADOR                 = 16
) (
    input  logic                                          i_clock,
    input  logic                                          i_reset,
    input  logic                                          i_enable_etapa,
    input  logic                                          i_valid,
    input  logic [CANT_BITS_FLAG_BRANCH-1:0]              i_flag_branch,
    input  logic [CANT_BITS_INSTRUCTION_INDEX_BRANCH-1:0] i_instruction_index_branch,
    input  logic [CANT_BITS_ADDR-1:0]                     i_pc_plus_1,
    input  logic [CANT_BITS_REGISTROS-1:0]                i_dato_rs,
    input  logic [CANT_BITS_REGISTROS-1:0]                i_dato_rt,
    output logic                                          o_branch_control,
    output logic [CANT_BITS_ADDR-1:0]                     o_branch_dir,
    output logic [CANT_BITS_ADDR-1:0]                     o_link_dir,
    output logic                                          o_flush,
    output logic                                          o_busy,
    output logic                                          o_disable_for_exception_to_hazard_detection_unit,
    output logic [CANT_BITS_CONTADOR-1:0]                 o_cant_branches_tomados
);

    localparam int unsigned FLUSH_W = (CANT_CICLOS_FLUSH > 1) ? $clog2(CANT_CICLOS_FLUSH) : 1;

    localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_J    = CANT_BITS_FLAG_BRANCH'(1);
    localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_JAL  = CANT_BITS_FLAG_BRANCH'(2);
    localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_JR   = CANT_BITS_FLAG_BRANCH'(3);
    localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_JALR = CANT_BITS_FLAG_BRANCH'(4);
    localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_BEQ  = CANT_BITS_FLAG_BRANCH'(5);
    localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_BNE  = CANT_BITS_FLAG_BRANCH'(6);
    localparam logic [CANT_BITS_FLAG_BRANCH-1:0] FLAG_RSV  = CANT_BITS_FLAG_BRANCH'(7);

    typedef enum logic [1:0] {IDLE, FLUSH, EXCEPTION} state_t;

    state_t                          state, state_next;
    logic [FLUSH_W-1:0]              flush_cnt, flush_cnt_next;
    logic                            is_jump_imm, is_jump_reg, is_link, is_beq, is_bne;
    logic                            exception_cond, taken, capture;
    logic [CANT_BITS_ADDR-1:0]       offset_ext, target;
    logic                            unused_index_bits;

    // Upper index bits only matter for wider address configurations.
    assign unused_index_bits = ^i_instruction_index_branch;

    always_comb begin
        is_jump_imm    = (i_flag_branch == FLAG_J)  || (i_flag_branch == FLAG_JAL);
        is_jump_reg    = (i_flag_branch == FLAG_JR) || (i_flag_branch == FLAG_JALR);
        is_link        = (i_flag_branch == FLAG_JAL) || (i_flag_branch == FLAG_JALR);
        is_beq         = (i_flag_branch == FLAG_BEQ);
        is_bne         = (i_flag_branch == FLAG_BNE);
        // A register target that does not fit in instruction memory is treated as an exception.
        exception_cond = (i_flag_branch == FLAG_RSV) ||
                         (is_jump_reg && ((i_dato_rs >> CANT_BITS_ADDR) != '0));
        taken          = is_jump_imm || is_jump_reg ||
                         (is_beq && (i_dato_rs == i_dato_rt)) ||
                         (is_bne && (i_dato_rs != i_dato_rt));
        capture        = i_enable_etapa && i_valid && (state == IDLE);
        offset_ext     = CANT_BITS_ADDR'({{16{i_instruction_index_branch[15]}},
                                          i_instruction_index_branch[15:0]});
        target         = '0;
        if (is_jump_imm)
            target = i_instruction_index_branch[CANT_BITS_ADDR-1:0];
        else if (is_jump_reg)
            target = i_dato_rs[CANT_BITS_ADDR-1:0];
        else if (is_beq || is_bne)
            target = i_pc_plus_1 + offset_ext;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state                   <= IDLE;
            flush_cnt               <= '0;
            o_branch_control        <= 1'b0;
            o_branch_dir            <= '0;
            o_link_dir              <= '0;
            o_cant_branches_tomados <= '0;
        end else begin
            state            <= state_next;
            flush_cnt        <= flush_cnt_next;
            o_branch_control <= capture && !exception_cond && taken;
            if (capture && !exception_cond) begin
                o_branch_dir <= taken ? target : '0;
                if (taken && (o_cant_branches_tomados != '1))
                    o_cant_branches_tomados <= o_cant_branches_tomados + 1'b1;
                if (is_link)
                    o_link_dir <= i_pc_plus_1 + 1'b1;
            end
        end
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            IDLE: begin
                if (capture) begin
                    if (exception_cond) begin
                        state_next = EXCEPTION;
                    end else if (taken) begin
                        state_next     = FLUSH;
                        flush_cnt_next = FLUSH_W'(CANT_CICLOS_FLUSH - 1);
                    end
                end
            end
            FLUSH: begin
                if (i_enable_etapa) begin
                    if (flush_cnt == '0)
                        state_next = IDLE;
                    else
                        flush_cnt_next = flush_cnt - 1'b1;
                end
            end
            EXCEPTION: state_next = EXCEPTION;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        o_flush = (state == FLUSH);
        o_busy  = (state == FLUSH);
        o_disable_for_exception_to_hazard_detection_unit = (state == EXCEPTION);
    end

endmodule
